// File: rtl/micro_uart_pkg.sv
// Shared types and constants for the micro UART two-master arbiter.
package micro_uart_pkg;

    // Sequencer states: baud preload, wait for a request, bus strobe, completion.
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    // Register-select encoding as seen on m_baud.
    localparam logic DATA_REG = 1'b0;
    localparam logic BAUD_REG = 1'b1;

    // Command latched when a master wins arbitration.
    typedef struct packed {
        logic who;   // winning master index
        logic wr;    // 1 = write, 0 = read
    } cmd_t;

    // Master index to one-hot request/ack vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/micro_uart_rr_arb.sv
// Two-way round-robin picker. ptr names the master that currently has
// priority; ptr_next is where priority goes after the granted master is
// served (away from it unless advance is low, i.e. the master is locked).
module micro_uart_rr_arb
    import micro_uart_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr_next
);

    logic any_req;
    logic gidx;

    // Favoured master wins if requesting, otherwise the other one.
    always_comb begin
        any_req  = |req;
        gidx     = req[ptr] ? ptr : ~ptr;
        grant    = any_req ? onehot2(gidx) : 2'b00;
        ptr_next = any_req ? (advance ? ~gidx : gidx) : ptr;
    end

endmodule

// File: rtl/micro_uart_arb.sv
// Two-master sequencer in front of micro_uart: optional baud preload after
// reset, then round-robin (with lock) single-access transactions.
module micro_uart_arb
    import micro_uart_pkg::*;
#(
    parameter bit          INIT_BAUD_EN = 1'b1,
    parameter logic [15:0] INIT_BAUD    = 16'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  m_req,
    input  logic [1:0]  m_lock,
    input  logic [1:0]  m_write,
    input  logic [1:0]  m_baud,
    input  logic [15:0] m_wdata0,
    input  logic [15:0] m_wdata1,
    output logic [1:0]  m_ack,
    output logic [15:0] m_rdata,
    output logic        init_done,
    output logic        data_select,
    output logic        baud_select,
    output logic        cpu_read,
    output logic        cpu_write,
    output logic [15:0] cpu_wdata,
    input  logic [15:0] cpu_rdata
);

    localparam state_t RST_STATE = INIT_BAUD_EN ? ST_INIT : ST_IDLE;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    cmd_t        cmd_q, cmd_d;
    logic        init_done_q, init_done_d;
    logic [1:0]  m_ack_q, m_ack_d;
    logic [15:0] m_rdata_q, m_rdata_d;
    logic        data_select_q, data_select_d;
    logic        baud_select_q, baud_select_d;
    logic        cpu_read_q, cpu_read_d;
    logic        cpu_write_q, cpu_write_d;
    logic [15:0] cpu_wdata_q, cpu_wdata_d;

    logic [1:0]  arb_req;
    logic [1:0]  arb_grant;
    logic        arb_ptr_next;
    logic        arb_advance;
    logic        win;
    logic        win_wr;
    logic        win_baud;

    // During ACK the picker only sees the served master, so its ptr_next
    // reflects that master and its lock, regardless of the live requests.
    always_comb begin
        arb_req     = (state_q == ST_ACK) ? onehot2(cmd_q.who) : m_req;
        arb_advance = ~m_lock[cmd_q.who];
    end

    micro_uart_rr_arb u_rr_arb (
        .req      (arb_req),
        .ptr      (ptr_q),
        .advance  (arb_advance),
        .grant    (arb_grant),
        .ptr_next (arb_ptr_next)
    );

    // Next-state and next-output logic; outputs are set one cycle ahead so
    // they are visible while the FSM sits in the state they belong to.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cmd_d         = cmd_q;
        init_done_d   = init_done_q;
        m_ack_d       = 2'b00;
        m_rdata_d     = m_rdata_q;
        data_select_d = data_select_q;
        baud_select_d = baud_select_q;
        cpu_read_d    = 1'b0;
        cpu_write_d   = 1'b0;
        cpu_wdata_d   = cpu_wdata_q;
        win           = arb_grant[1];
        win_wr        = m_write[win];
        win_baud      = m_baud[win];

        case (state_q)
            ST_INIT: begin
                if (!cpu_write_q) begin
                    // First cycle: launch the baud preload write.
                    cpu_write_d   = 1'b1;
                    data_select_d = 1'b0;
                    baud_select_d = 1'b1;
                    cpu_wdata_d   = INIT_BAUD;
                end else begin
                    // Preload strobe has been on the bus for its cycle.
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (|m_req) begin
                    cmd_d.who     = win;
                    cmd_d.wr      = win_wr;
                    cpu_write_d   = win_wr;
                    cpu_read_d    = ~win_wr;
                    data_select_d = (win_baud == DATA_REG);
                    baud_select_d = (win_baud == BAUD_REG);
                    if (win_wr) begin
                        cpu_wdata_d = win ? m_wdata1 : m_wdata0;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Strobe is on the bus now; read data is valid this cycle.
                m_ack_d   = onehot2(cmd_q.who);
                m_rdata_d = cmd_q.wr ? 16'h0000 : cpu_rdata;
                state_d   = ST_ACK;
            end
            ST_ACK: begin
                ptr_d   = arb_ptr_next;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RST_STATE;
            ptr_q         <= 1'b0;
            cmd_q         <= '0;
            init_done_q   <= ~INIT_BAUD_EN;
            m_ack_q       <= 2'b00;
            m_rdata_q     <= 16'h0000;
            data_select_q <= 1'b0;
            baud_select_q <= 1'b0;
            cpu_read_q    <= 1'b0;
            cpu_write_q   <= 1'b0;
            cpu_wdata_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cmd_q         <= cmd_d;
            init_done_q   <= init_done_d;
            m_ack_q       <= m_ack_d;
            m_rdata_q     <= m_rdata_d;
            data_select_q <= data_select_d;
            baud_select_q <= baud_select_d;
            cpu_read_q    <= cpu_read_d;
            cpu_write_q   <= cpu_write_d;
            cpu_wdata_q   <= cpu_wdata_d;
        end
    end

    assign m_ack       = m_ack_q;
    assign m_rdata     = m_rdata_q;
    assign init_done   = init_done_q;
    assign data_select = data_select_q;
    assign baud_select = baud_select_q;
    assign cpu_read    = cpu_read_q;
    assign cpu_write   = cpu_write_q;
    assign cpu_wdata   = cpu_wdata_q;

endmodule

// File: tb/tb_micro_uart_arb.sv
// Scoreboard bench for micro_uart_arb: per-master transaction queues drive
// the requests, a service-order model predicts bus strobes and acks, and a
// negedge monitor checks every strobe and ack against the prediction.
module tb_micro_uart_arb;

    localparam logic [15:0] INIT_BAUD = 16'h0145;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  m_req, m_lock, m_write, m_baud;
    logic [15:0] m_wdata0, m_wdata1;
    logic [1:0]  m_ack;
    logic [15:0] m_rdata;
    logic        init_done, data_select, baud_select, cpu_read, cpu_write;
    logic [15:0] cpu_wdata, cpu_rdata;

    micro_uart_arb #(.INIT_BAUD_EN(1'b1), .INIT_BAUD(INIT_BAUD)) dut (
        .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_lock(m_lock),
        .m_write(m_write), .m_baud(m_baud), .m_wdata0(m_wdata0), .m_wdata1(m_wdata1),
        .m_ack(m_ack), .m_rdata(m_rdata), .init_done(init_done),
        .data_select(data_select), .baud_select(baud_select),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple UART register model: data reads pop (increment) the data value.
    logic [15:0] uart_data = 16'h00A5;
    logic [15:0] uart_baud = 16'h0000;
    assign cpu_rdata = cpu_read ? (baud_select ? uart_baud : uart_data) : 16'hDEAD;
    always @(posedge clk) begin
        if (cpu_write) begin
            if (baud_select) uart_baud <= cpu_wdata;
            else             uart_data <= cpu_wdata;
        end else if (cpu_read && data_select) begin
            uart_data <= uart_data + 16'd1;
        end
    end

    typedef struct packed { bit lock; bit wr; bit bd; logic [15:0] wd; } txn_t;
    typedef struct packed { bit init; bit m; bit wr; bit bd; logic [15:0] wd; logic [15:0] rd; } exp_t;

    txn_t mq0[$];
    txn_t mq1[$];
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: who is favoured, and the UART register contents.
    bit          model_fav  = 1'b0;
    logic [15:0] model_data = 16'h00A5;
    logic [15:0] model_baud = 16'h0000;

    int start_cyc, last_strobe_cyc, last_ack_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_init();
        exp_t e;
        e = '0;
        e.init = 1'b1; e.wr = 1'b1; e.bd = 1'b1; e.wd = INIT_BAUD;
        model_baud = INIT_BAUD;
        exp_q.push_back(e);
    endtask

    // Predict service order for everything currently queued: favoured master
    // first when both wait, favour moves away from the served master unless
    // its transaction was locked.
    task automatic plan();
        int i0, i1;
        bit r0, r1, w;
        txn_t t;
        exp_t e;
        i0 = 0; i1 = 0;
        while (i0 < mq0.size() || i1 < mq1.size()) begin
            r0 = (i0 < mq0.size());
            r1 = (i1 < mq1.size());
            w  = (r0 && r1) ? model_fav : r1;
            t  = w ? mq1[i1] : mq0[i0];
            e  = '0;
            e.m = w; e.wr = t.wr; e.bd = t.bd; e.wd = t.wd;
            if (t.wr) begin
                e.rd = 16'h0000;
                if (t.bd) model_baud = t.wd; else model_data = t.wd;
            end else if (t.bd) begin
                e.rd = model_baud;
            end else begin
                e.rd = model_data;
                model_data = model_data + 16'd1;
            end
            exp_q.push_back(e);
            model_fav = t.lock ? w : ~w;
            if (w) i1++; else i0++;
        end
    endtask

    task automatic drive();
        m_req = {mq1.size() != 0, mq0.size() != 0};
        if (mq0.size() != 0) begin
            m_lock[0] = mq0[0].lock; m_write[0] = mq0[0].wr;
            m_baud[0] = mq0[0].bd;   m_wdata0   = mq0[0].wd;
        end else begin
            m_lock[0] = 1'b0;
        end
        if (mq1.size() != 0) begin
            m_lock[1] = mq1[0].lock; m_write[1] = mq1[0].wr;
            m_baud[1] = mq1[0].bd;   m_wdata1   = mq1[0].wd;
        end else begin
            m_lock[1] = 1'b0;
        end
    endtask

    function automatic txn_t mk(input bit lock, input bit wr, input bit bd, input logic [15:0] wd);
        txn_t t;
        t.lock = lock; t.wr = wr; t.bd = bd; t.wd = wd;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom));
    endfunction

    // Run everything queued to completion. Called just after a rising edge;
    // a master moves to its next transaction in the cycle after its ack so
    // its lock stays valid through the ack cycle.
    task automatic run_batch();
        int guard;
        logic [1:0] ack_prev;
        plan();
        start_cyc = cyc;
        drive();
        ack_prev = 2'b00;
        guard = 0;
        while ((mq0.size() != 0 || mq1.size() != 0) && guard < 400) begin
            @(posedge clk); #1;
            if (ack_prev[0] && mq0.size() != 0) mq0.delete(0);
            if (ack_prev[1] && mq1.size() != 0) mq1.delete(0);
            drive();
            ack_prev = m_ack;
            guard++;
        end
        if (guard >= 400) begin
            check("batch_timeout", 32'(guard), 32'd0);
            mq0.delete(); mq1.delete(); drive();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every strobe and every ack with the scoreboard.
    bit   ack_pending = 1'b0;
    int   ack_due = 0;
    bit   init_chk = 1'b0;
    int   init_due = 0;
    exp_t cur;
    logic [15:0] last_rd = 16'h0000;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ack_pending = 1'b0;
                init_chk    = 1'b0;
                last_rd     = 16'h0000;
            end else begin
                if (init_chk && cyc == init_due) begin
                    check("init_done_rise", 32'(init_done), 32'd1);
                    init_chk = 1'b0;
                end
                if (cpu_read || cpu_write) begin
                    check("single_strobe", 32'(cpu_read & cpu_write), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 32'(cpu_write), 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_is_write", 32'(cpu_write), 32'(e.wr));
                        check("selects", {30'd0, data_select, baud_select}, e.bd ? 32'd1 : 32'd2);
                        if (e.wr) check("cpu_wdata", 32'(cpu_wdata), 32'(e.wd));
                        check("rdata_hold", 32'(m_rdata), 32'(last_rd));
                        last_strobe_cyc = cyc;
                        if (e.init) begin
                            check("init_done_low_at_init_write", 32'(init_done), 32'd0);
                            init_chk = 1'b1;
                            init_due = cyc + 1;
                        end else begin
                            cur = e;
                            ack_pending = 1'b1;
                            ack_due = cyc + 1;
                        end
                    end
                end
                if (m_ack != 2'b00) begin
                    check("ack_after_init", 32'(init_done), 32'd1);
                    if (!ack_pending) begin
                        check("unexpected_ack", 32'(m_ack), 32'd0);
                    end else begin
                        check("ack_latency", 32'(cyc), 32'(ack_due));
                        check("ack_master", 32'(m_ack), cur.m ? 32'd2 : 32'd1);
                        check("ack_rdata", 32'(m_rdata), 32'(cur.rd));
                        last_rd = cur.rd;
                        ack_pending = 1'b0;
                        last_ack_cyc = cyc;
                    end
                end else if (ack_pending && cyc > ack_due) begin
                    check("missing_ack", 32'(cyc), 32'(ack_due));
                    ack_pending = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        logic [15:0] saved_data;
        reset_n = 1'b0;
        m_req = 2'b00; m_lock = 2'b00; m_write = 2'b00; m_baud = 2'b00;
        m_wdata0 = 16'h0000; m_wdata1 = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_strobes", {30'd0, cpu_read, cpu_write}, 32'd0);
        check("rst_selects", {30'd0, data_select, baud_select}, 32'd0);
        check("rst_ack", 32'(m_ack), 32'd0);
        check("rst_rdata_wdata", {m_rdata, cpu_wdata}, 32'd0);

        // Baud preload, with both masters already requesting during INIT.
        push_init();
        reset_n = 1'b1;
        mq0.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0100));
        mq1.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0122));
        run_batch();

        // Single data read from m0: strobe one cycle after the sampled request,
        // ack the cycle after that.
        mq0.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000));
        run_batch();
        check("read_strobe_latency", 32'(last_strobe_cyc - start_cyc), 32'd1);
        check("read_ack_latency", 32'(last_ack_cyc - start_cyc), 32'd2);

        // Simultaneous requests, two each, no lock: strict alternation.
        for (int i = 0; i < 2; i++) begin
            mq0.push_back(mk(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom)));
            mq1.push_back(mk(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom)));
        end
        run_batch();

        // m1 keeps the grant with lock for three writes while m0 waits.
        mq0.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1111));
        run_batch();
        for (int i = 0; i < 3; i++) mq1.push_back(mk(1'b1, 1'b1, 1'b0, 16'($urandom)));
        mq0.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000));
        run_batch();

        // Random mixes of locks, reads, writes and register selects.
        for (int b = 0; b < 20; b++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            for (int i = 0; i < n0; i++) mq0.push_back(rnd_txn());
            for (int i = 0; i < n1; i++) mq1.push_back(rnd_txn());
            run_batch();
        end

        // Reset while an m1 write is on the bus.
        saved_data = model_data;
        mq1.push_back(mk(1'b0, 1'b1, 1'b0, 16'hBEEF));
        plan();
        drive();
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!cpu_write && guard < 20);
        check("reset_test_strobe_seen", 32'(cpu_write), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async_clear_strobe", {30'd0, cpu_read, cpu_write}, 32'd0);
        check("async_clear_ack_init", {29'd0, m_ack, init_done}, 32'd0);
        check("async_clear_bus", {15'd0, data_select, cpu_wdata}, 32'd0);
        mq1.delete();
        drive();
        exp_q.delete();
        model_data = saved_data;
        model_fav  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_ack_in_reset", 32'(m_ack), 32'd0);
        end
        @(posedge clk); #1;
        push_init();
        reset_n = 1'b1;
        mq0.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0000));
        mq1.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000));
        run_batch();

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
